// File: rtl/add_sub_pkg.sv
// Shared widths, special encodings and the per-stage record for the add/sub normalizer.
package add_sub_pkg;

  localparam int SIZE_EXP  = 8;
  localparam int SIZE_FRAC = 23;
  localparam int SIZE_MANT = SIZE_FRAC + 5;
  localparam int SIZE_DATA = 1 + SIZE_EXP + SIZE_FRAC;
  localparam int LZC_W     = $clog2(SIZE_MANT);

  localparam logic [SIZE_EXP-1:0]  EXP_MAX = 8'hFF;
  localparam logic [SIZE_DATA-1:0] QNAN    = 32'h7FC00000;

  typedef enum logic [1:0] {
    NORMAL,
    ZERO,
    INF,
    NAN
  } kind_e;

  typedef struct packed {
    logic                 valid;
    logic                 sign;
    logic [SIZE_EXP-1:0]  exp;
    logic [SIZE_MANT-1:0] mant;
    kind_e                kind;
  } stage_t;

  function automatic logic [SIZE_DATA-1:0] inf_word(input logic sign);
    return {sign, EXP_MAX, {SIZE_FRAC{1'b0}}};
  endfunction

endpackage

// File: rtl/add_sub_normalize_pipe_if.sv
// Operand/result handshake bundle; slave is the normalizer, master is its environment.
interface add_sub_normalize_pipe_if;
  import add_sub_pkg::*;

  logic                 i_valid;
  logic                 o_ready;
  logic                 i_sign;
  logic [SIZE_EXP-1:0]  i_exp;
  logic [SIZE_MANT-1:0] i_mant;
  logic                 o_valid;
  logic                 i_ready;
  logic [SIZE_DATA-1:0] o_result;

  modport slave (
    input  i_valid, i_sign, i_exp, i_mant, i_ready,
    output o_ready, o_valid, o_result
  );

  modport master (
    output i_valid, i_sign, i_exp, i_mant, i_ready,
    input  o_ready, o_valid, o_result
  );

endinterface

// File: rtl/add_sub_lzc.sv
// Combinational leading-zero counter; an all-zero input returns WIDTH.
module add_sub_lzc #(
  parameter int WIDTH = 27,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CNT_W-1:0] cnt_o
);

  // Scanning upward lets the highest set bit be the last (winning) assignment.
  always_comb begin
    cnt_o = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data_i[i]) cnt_o = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/add_sub_normalize_pipe.sv
// Normalize, round-to-nearest-even and pack the raw add/sub result: 3 cycles, 1 per cycle.
// A held output (o_valid & ~i_ready) freezes every stage and drops o_ready.
module add_sub_normalize_pipe
  import add_sub_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst,
  add_sub_normalize_pipe_if.slave bus
);

  logic en;
  assign en          = ~bus.o_valid | bus.i_ready;
  assign bus.o_ready = en;

  stage_t               s1_d, s1_q, s2_d, s2_q;
  logic [LZC_W-1:0]     lzc_cnt, s1_lzc_d, s1_lzc_q;
  logic                 s3_valid_q;
  logic [SIZE_DATA-1:0] result_d, result_q;

  add_sub_lzc #(
    .WIDTH (SIZE_MANT - 1),
    .CNT_W (LZC_W)
  ) u_lzc (
    .data_i (bus.i_mant[SIZE_MANT-2:0]),
    .cnt_o  (lzc_cnt)
  );

  // Stage 1: classify, absorb a carry-out, pick the left-shift amount.
  always_comb begin
    s1_d.valid = bus.i_valid;
    s1_d.sign  = bus.i_sign;
    s1_d.exp   = bus.i_exp;
    s1_d.mant  = bus.i_mant;
    s1_d.kind  = NORMAL;
    s1_lzc_d   = '0;
    if (bus.i_exp == EXP_MAX) begin
      s1_d.kind = (|bus.i_mant[SIZE_MANT-3:3]) ? NAN : INF;
    end else if (bus.i_mant[SIZE_MANT-1]) begin
      s1_d.mant = {1'b0, bus.i_mant[SIZE_MANT-1:2], |bus.i_mant[1:0]};
      s1_d.exp  = bus.i_exp + SIZE_EXP'(1);
    end else if (bus.i_mant == '0) begin
      s1_d.kind = ZERO;
    end else begin
      s1_lzc_d = lzc_cnt;
    end
  end

  // Stage 2: shift left and lower the exponent; a non-positive exponent flushes to zero.
  logic signed [SIZE_EXP:0] exp_adj;
  assign exp_adj = $signed({1'b0, s1_q.exp})
                 - $signed({{(SIZE_EXP + 1 - LZC_W){1'b0}}, s1_lzc_q});

  always_comb begin
    s2_d = s1_q;
    if (s1_q.kind == NORMAL) begin
      if (s1_q.exp == EXP_MAX) begin
        s2_d.kind = INF;
      end else if (exp_adj[SIZE_EXP] || (exp_adj == '0)) begin
        s2_d.kind = ZERO;
      end else begin
        s2_d.exp  = exp_adj[SIZE_EXP-1:0];
        s2_d.mant = s1_q.mant << s1_lzc_q;
      end
    end
  end

  // Stage 3: RNE on guard/round/sticky, then pack.
  logic                  round_up;
  logic [SIZE_FRAC+1:0]  sig;
  logic [SIZE_EXP-1:0]   exp_r;
  logic [SIZE_FRAC-1:0]  frac;

  assign round_up = s2_q.mant[2] & (s2_q.mant[1] | s2_q.mant[0] | s2_q.mant[3]);
  assign sig      = s2_q.mant[SIZE_MANT-1:3] + {{(SIZE_FRAC + 1){1'b0}}, round_up};
  assign exp_r    = s2_q.exp + {{(SIZE_EXP - 1){1'b0}}, sig[SIZE_FRAC+1]};
  // A rounding overflow leaves sig at exactly 2.0, so the shifted fraction is zero.
  assign frac     = sig[SIZE_FRAC+1] ? sig[SIZE_FRAC:1] : sig[SIZE_FRAC-1:0];

  always_comb begin
    result_d = '0;
    case (s2_q.kind)
      NORMAL:  result_d = (exp_r == EXP_MAX) ? inf_word(s2_q.sign)
                                             : {s2_q.sign, exp_r, frac};
      ZERO:    result_d = {s2_q.sign, {(SIZE_DATA - 1){1'b0}}};
      INF:     result_d = inf_word(s2_q.sign);
      NAN:     result_d = QNAN;
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_q       <= '0;
      s1_lzc_q   <= '0;
      s2_q       <= '0;
      s3_valid_q <= 1'b0;
      result_q   <= '0;
    end else if (en) begin
      s1_q       <= s1_d;
      s1_lzc_q   <= s1_lzc_d;
      s2_q       <= s2_d;
      s3_valid_q <= s2_q.valid;
      result_q   <= result_d;
    end
  end

  assign bus.o_valid  = s3_valid_q;
  assign bus.o_result = result_q;

endmodule

// File: tb/tb_add_sub_normalize_pipe.sv
// Randomized and directed bench for add_sub_normalize_pipe against a value-level reference model.
module tb_add_sub_normalize_pipe;
  import add_sub_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  bit          use_force = 1'b0;
  logic [31:0] force_exp = '0;
  string       cur_tag = "rand";

  always #5 clk = ~clk;

  add_sub_normalize_pipe_if bus();

  add_sub_normalize_pipe dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, expv);
    end
  endtask

  // Value-level model: mantissa is an integer scaled by 2^-26, renormalized to bit 26.
  function automatic logic [31:0] ref_model(input logic s, input logic [7:0] e, input logic [27:0] m);
    int     p;
    int     ex;
    longint mm;
    int     keep;
    int     rem;
    if (e == 8'hFF) return (m[25:3] != 0) ? 32'h7FC00000 : {s, 8'hFF, 23'h0};
    if (m == 0) return {s, 31'h0};
    p = 27;
    while (!m[p]) p--;
    ex = int'(e) + p - 26;
    if (p == 27) begin
      mm = longint'(m >> 1) | longint'(m & 28'd1);
      if (ex >= 255) return {s, 8'hFF, 23'h0};
    end else begin
      mm = longint'(m) << (26 - p);
    end
    if (ex <= 0) return {s, 31'h0};
    keep = int'(mm >> 3);
    rem  = int'(mm & 64'd7);
    if (rem > 4 || (rem == 4 && (keep % 2) == 1)) keep++;
    if (keep >= (1 << 24)) begin
      keep = keep >> 1;
      ex++;
    end
    if (ex >= 255) return {s, 8'hFF, 23'h0};
    return {s, 8'(ex), 23'(keep)};
  endfunction

  task automatic gen_op(output logic s, output logic [7:0] e, output logic [27:0] m);
    int sel;
    s   = 1'($urandom);
    sel = $urandom_range(0, 9);
    case (sel)
      0:       e = 8'd0;
      1:       e = 8'd1;
      2:       e = 8'd2;
      3:       e = 8'd253;
      4:       e = 8'd254;
      5:       e = 8'd255;
      default: e = 8'($urandom_range(1, 254));
    endcase
    m = 28'($urandom) >> $urandom_range(0, 27);
    sel = $urandom_range(0, 9);
    if (sel == 0)      m = 28'd0;
    else if (sel == 1) m = {m[27:3], 3'b100};
    else if (sel == 2) m = 28'h7FFFFFC;
  endtask

  // One clock: drive at the falling edge, then record the transfers the next rising edge performs.
  task automatic cycle(input bit v, input logic s, input logic [7:0] e, input logic [27:0] m,
                       input bit rdy, output bit acc);
    logic [31:0] ev;
    string       tg;
    @(negedge clk);
    bus.i_valid = v;
    bus.i_sign  = s;
    bus.i_exp   = e;
    bus.i_mant  = m;
    bus.i_ready = rdy;
    #1;
    acc = bus.i_valid && bus.o_ready;
    if (bus.o_valid && bus.i_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("extra_out", 32'(bus.o_valid), 32'd0);
      end else begin
        ev = exp_q.pop_front();
        tg = tag_q.pop_front();
        n_out++;
        check_eq(tg, bus.o_result, ev);
      end
    end
    if (acc) begin
      exp_q.push_back(use_force ? force_exp : ref_model(s, e, m));
      tag_q.push_back(use_force ? cur_tag : "rand");
    end
  endtask

  task automatic directed(input string tag, input logic s, input logic [7:0] e,
                          input logic [27:0] m, input logic [31:0] expv);
    bit acc;
    int lat = 0;
    use_force = 1'b1;
    force_exp = expv;
    cur_tag   = tag;
    cycle(1'b1, s, e, m, 1'b1, acc);
    use_force = 1'b0;
    check_eq({tag, "_acc"}, 32'(acc), 32'd1);
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      cycle(1'b0, s, e, m, 1'b1, acc);
      if (bus.o_valid) lat = k;
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'd3);
  endtask

  initial begin
    bit          acc;
    logic        s;
    logic [7:0]  e;
    logic [27:0] m;
    logic [31:0] held;
    logic        ss[5];
    logic [7:0]  es[5];
    logic [27:0] ms[5];
    int          idx;
    int          base;

    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_sign  = 1'b0;
    bus.i_exp   = '0;
    bus.i_mant  = '0;
    bus.i_ready = 1'b1;
    held = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ovalid", 32'(bus.o_valid), 32'd0);
    check_eq("rst_result", bus.o_result, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("idle_ordy", 32'(bus.o_ready), 32'd1);

    directed("one_plus_one", 1'b0, 8'd127, 28'h8000000, 32'h40000000);
    directed("cancel",       1'b0, 8'd127, 28'h1000000, 32'h3E800000);
    directed("rnd_carry",    1'b0, 8'd127, 28'h7FFFFFC, 32'h40000000);
    directed("tie_even",     1'b0, 8'd127, 28'h4000004, 32'h3F800000);
    directed("rnd_up",       1'b0, 8'd127, 28'h400000C, 32'h3F800002);
    directed("ovf_inf",      1'b0, 8'd254, 28'h8000000, 32'h7F800000);
    directed("flush",        1'b0, 8'd2,   28'h0800000, 32'h00000000);
    directed("neg_zero",     1'b1, 8'd127, 28'h0000000, 32'h80000000);
    directed("nan",          1'b1, 8'd255, 28'h4400000, 32'h7FC00000);
    directed("inf_in",       1'b1, 8'd255, 28'h4000000, 32'hFF800000);

    // Five back-to-back operands with the sink stalled for four cycles mid-stream.
    for (int i = 0; i < 5; i++) gen_op(ss[i], es[i], ms[i]);
    base = n_out;
    idx  = 0;
    for (int c = 0; c < 40; c++) begin
      cycle(idx < 5, ss[idx % 5], es[idx % 5], ms[idx % 5], !(c >= 4 && c < 8), acc);
      if (c >= 4 && c < 8) begin
        check_eq("stall_ordy", 32'(bus.o_ready), 32'd0);
        if (c == 4) held = bus.o_result;
        else        check_eq("stall_stable", bus.o_result, held);
      end
      if (acc) idx++;
      if (idx == 5 && exp_q.size() == 0) break;
    end
    check_eq("bp_count", 32'(n_out - base), 32'd5);
    check_eq("bp_left", 32'(exp_q.size()), 32'd0);

    gen_op(s, e, m);
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, s, e, m, $urandom_range(0, 4) != 0, acc);
      if (acc) gen_op(s, e, m);
    end
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) cycle(1'b0, s, e, m, 1'b1, acc);
    check_eq("rand_drain", 32'(exp_q.size()), 32'd0);

    // Reset with three operands in flight: nothing may emerge afterwards.
    for (int i = 0; i < 3; i++) begin
      gen_op(s, e, m);
      cycle(1'b1, s, e, m, 1'b1, acc);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.i_valid = 1'b0;
    exp_q.delete();
    tag_q.delete();
    @(negedge clk);
    #1;
    check_eq("rst_mid_ovalid", 32'(bus.o_valid), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, s, e, m, 1'b1, acc);
      check_eq("post_rst_quiet", 32'(bus.o_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
